pipelined_rca: RTL and testbench

//  Parametrised, pipelined ripple-carry adder/subtractor. WIDTH-bit operands are split into

---
 rtl/pipelined_rca_pkg.sv | 13 +
 rtl/pipelined_rca_slice.sv | 31 +++
 rtl/pipelined_rca.sv | 139 +++++++++++++
 tb/tb_pipelined_rca.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_rca_pkg.sv
// Shared definitions for the pipelined ripple-carry adder: default geometry
// and the full-adder cell used by every slice.
package pipelined_rca_pkg;

    localparam int RCA_WIDTH  = 16;
    localparam int RCA_STAGES = 4;

    // One full-adder cell, returned as {carry_out, sum}.
    function automatic logic [1:0] fa(input logic a, input logic b, input logic c);
        return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

endpackage

// File: rtl/pipelined_rca_slice.sv
// Combinational N-bit ripple adder built from full-adder cells. Also exposes
// the carry into its MSB so the top slice can derive signed overflow.
module rca_slice
    import pipelined_rca_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co,
    output logic         c_msb_in
);

    logic [N:0] c;

    // Ripple the carry bit by bit through the full-adder cells.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < N; i++) begin
            {c[i+1], s[i]} = fa(a[i], b[i], c[i]);
        end
    end

    assign co       = c[N];
    assign c_msb_in = c[N-1];

endmodule

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder/subtractor. The operands are cut into STAGES
// chunks of CHUNK bits; stage k ripples chunk k and registers its carry, so one
// operation is accepted per cycle and completes STAGES cycles later.
//
// Each stage carries a WIDTH-bit word whose low bits are the sum chunks already
// produced and whose high bits are the still-unprocessed chunks of A, so all sum
// bits of one operation leave the last stage together. The inverted-or-not B
// operand is shifted down one chunk per stage and is dropped once consumed.
module pipelined_rca
    import pipelined_rca_pkg::*;
#(
    parameter int WIDTH  = RCA_WIDTH,
    parameter int STAGES = RCA_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CHUNK = WIDTH / STAGES;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_geometry
        $error("pipelined_rca: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
    end

    // Subtraction is A + ~B + 1; the mode is folded into the operand and carry
    // here so it travels with the op and never needs to be re-examined.
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    assign b_eff = sub ? ~B : B;
    assign c0    = sub ? 1'b1 : cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * CHUNK;

        logic [WIDTH-1:0]    acc_i;
        logic [WIDTH-LO-1:0] b_i;
        logic                c_i;
        logic                vld_i;
        logic [CHUNK-1:0]    s_chunk;
        logic                co;
        logic [WIDTH-1:0]    acc_o;
        logic [WIDTH-1:0]    acc_p;
        logic                c_p;
        logic                vld_p;

        if (k == 0) begin : g_head
            assign acc_i = A;
            assign b_i   = b_eff;
            assign c_i   = c0;
            assign vld_i = in_valid;
        end else begin : g_link
            assign acc_i = g_stage[k-1].acc_p;
            assign b_i   = g_stage[k-1].g_fwd.b_p;
            assign c_i   = g_stage[k-1].c_p;
            assign vld_i = g_stage[k-1].vld_p;
        end

        // Replace this stage's A chunk with its sum chunk; other bits pass through.
        always_comb begin
            acc_o               = acc_i;
            acc_o[LO +: CHUNK]  = s_chunk;
        end

        // ---- stage k register boundary: sum/A word, chunk carry, valid ----
        // Datapath registers load regardless of valid so bubbles stay deterministic.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc_p <= '0;
                c_p   <= 1'b0;
                vld_p <= 1'b0;
            end else if (en) begin
                acc_p <= acc_o;
                c_p   <= co;
                vld_p <= vld_i;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic                      c_msb_unused;
            logic [WIDTH-LO-CHUNK-1:0] b_p;

            rca_slice #(.N(CHUNK)) u_slice (
                .a        (acc_i[LO +: CHUNK]),
                .b        (b_i[CHUNK-1:0]),
                .ci       (c_i),
                .s        (s_chunk),
                .co       (co),
                .c_msb_in (c_msb_unused)
            );

            // Forward the unconsumed upper chunks of B to the next stage.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    b_p <= '0;
                end else if (en) begin
                    b_p <= b_i[WIDTH-LO-1:CHUNK];
                end
            end
        end else begin : g_tail
            logic c_msb;
            logic ovf_p;

            rca_slice #(.N(CHUNK)) u_slice (
                .a        (acc_i[LO +: CHUNK]),
                .b        (b_i[CHUNK-1:0]),
                .ci       (c_i),
                .s        (s_chunk),
                .co       (co),
                .c_msb_in (c_msb)
            );

            // Signed overflow: carry into the MSB disagrees with carry out of it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_p <= 1'b0;
                end else if (en) begin
                    ovf_p <= c_msb ^ co;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].vld_p;
    assign sum       = g_stage[STAGES-1].acc_p;
    assign cout      = g_stage[STAGES-1].c_p;
    assign ovf       = g_stage[STAGES-1].g_tail.ovf_p;

endmodule

// File: tb/tb_pipelined_rca.sv
// Bench for pipelined_rca at WIDTH=16, STAGES=4. Every accepted slot pushes its
// expected output onto a queue; once the queue holds STAGES entries the oldest
// is popped and becomes the expected output state until the next advance.
module tb_pipelined_rca;

    localparam int W = 16;
    localparam int S = 4;

    typedef struct packed {
        logic         v;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         in_valid = 1'b0;
    logic         sub = 1'b0;
    logic         cin = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         out_valid;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int   npass = 0;
    int   ntotal = 0;
    exp_t q[$];
    exp_t cur = '0;

    always #5 clk = ~clk;

    pipelined_rca #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .sub       (sub),
        .cin       (cin),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    // Behavioural reference: plain integer add/subtract, sign-rule overflow.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c, input logic s);
        exp_t       e;
        logic [W:0] r;
        e.v = 1'b1;
        if (s) begin
            e.s  = a - b;
            e.co = (a >= b);
            e.ov = (a[W-1] != b[W-1]) && (e.s[W-1] != a[W-1]);
        end else begin
            r    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
            e.s  = r[W-1:0];
            e.co = r[W];
            e.ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntotal++;
        assert (got === exp) npass++;
        else $error("FAIL %s: got %0h required %0h", tag, got, exp);
    endtask

    task automatic step(input string tag, input logic e, input logic v,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic s, input exp_t ex);
        en       = e;
        in_valid = v;
        A        = a;
        B        = b;
        cin      = c;
        sub      = s;
        @(posedge clk);
        #1;
        if (e) begin
            q.push_back(ex);
            if (q.size() >= S) cur = q.pop_front();
        end
        chk({tag, ".vld"}, 32'(out_valid), 32'(cur.v));
        if (cur.v)
            chk({tag, ".res"}, 32'({sum, cout, ovf}), 32'({cur.s, cur.co, cur.ov}));
    endtask

    task automatic op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic c, input logic s);
        step(tag, 1'b1, 1'b1, a, b, c, s, model(a, b, c, s));
    endtask

    task automatic bubble(input string tag);
        step(tag, 1'b1, 1'b0, 16'hA5A5, 16'h5A5A, 1'b1, 1'b1, '0);
    endtask

    task automatic stall(input string tag);
        step(tag, 1'b0, 1'b1, 16'hDEAD, 16'hBEEF, 1'b1, 1'b0, '0);
    endtask

    initial begin
        logic [W-1:0] corner [4];
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         re;
        logic         rv;
        logic         rc;
        logic         rs;

        corner[0] = 16'h0000;
        corner[1] = 16'hFFFF;
        corner[2] = 16'h8000;
        corner[3] = 16'h7FFF;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst.vld", 32'(out_valid), 32'd0);
        chk("rst.sum", 32'(sum), 32'd0);
        chk("rst.cout", 32'(cout), 32'd0);
        chk("rst.ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Add with latency and carry-out corner cases
        step("add_ff", 1'b1, 1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b0, exp_t'{1'b1, 16'h0100, 1'b0, 1'b0});
        step("add_wrap", 1'b1, 1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b0, exp_t'{1'b1, 16'h0000, 1'b1, 1'b0});
        // Subtract with and without overflow
        step("sub_ovf", 1'b1, 1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, exp_t'{1'b1, 16'h7FFF, 1'b1, 1'b1});
        step("sub_neg", 1'b1, 1'b1, 16'h0003, 16'h0005, 1'b1, 1'b1, exp_t'{1'b1, 16'hFFFE, 1'b0, 1'b0});
        step("add_ovf", 1'b1, 1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, exp_t'{1'b1, 16'h8000, 1'b0, 1'b1});
        for (int i = 0; i < S; i++) bubble("drain1");

        // Back-to-back stream, cin toggling
        for (int qv = 0; qv < 16; qv++) begin
            step("stream", 1'b1, 1'b1, W'(qv), W'(qv + 1), qv[0], 1'b0,
                 exp_t'{1'b1, W'(2 * qv + 1 + (qv % 2)), 1'b0, 1'b0});
        end
        for (int i = 0; i < S; i++) bubble("drain2");

        // Stall with a bubble in flight
        op("stl_x", 16'h1234, 16'h4321, 1'b1, 1'b0);
        bubble("stl_bub");
        op("stl_y", 16'h0010, 16'h0020, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) stall("stl_hold");
        for (int i = 0; i < S + 1; i++) bubble("stl_drain");

        // Mixed-mode back-to-back, then a stall while results sit on the output
        op("mix0", 16'hFFFF, 16'h0001, 1'b0, 1'b1);
        op("mix1", 16'hFFFF, 16'h0001, 1'b1, 1'b0);
        op("mix2", 16'h8000, 16'h8000, 1'b0, 1'b0);
        op("mix3", 16'h0000, 16'h0000, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) stall("mix_hold");
        for (int i = 0; i < S; i++) bubble("mix_drain");

        // Asynchronous reset with three ops in flight
        op("rstm0", 16'h1111, 16'h2222, 1'b0, 1'b0);
        op("rstm1", 16'h3333, 16'h4444, 1'b1, 1'b0);
        op("rstm2", 16'h5555, 16'h0001, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstm.vld", 32'(out_valid), 32'd0);
        chk("rstm.sum", 32'(sum), 32'd0);
        chk("rstm.cout", 32'(cout), 32'd0);
        chk("rstm.ovf", 32'(ovf), 32'd0);
        q.delete();
        cur = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < S + 2; i++) bubble("post_rst");
        op("post_op", 16'h0F0F, 16'h00F1, 1'b0, 1'b0);
        for (int i = 0; i < S; i++) bubble("post_drain");

        // Random stream with random enables and bubbles
        for (int i = 0; i < 400; i++) begin
            re = ($urandom_range(3) != 0);
            rv = ($urandom_range(2) != 0);
            ra = ($urandom_range(3) == 0) ? corner[$urandom_range(3)] : W'($urandom);
            rb = ($urandom_range(3) == 0) ? corner[$urandom_range(3)] : W'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            step("rnd", re, rv, ra, rb, rc, rs, rv ? model(ra, rb, rc, rs) : exp_t'('0));
        end
        for (int i = 0; i < S; i++) bubble("rnd_drain");

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
